// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg: register map offsets and CTRL bit positions for prog_timer
package prog_timer_pkg;
  localparam int STRIDE = 2;
  localparam int PERIOD_OFS = 0;
  localparam int CTRL_OFS = 1;
  localparam int CTRL_W = 3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE = 2;
  function automatic int status_addr(input int nch);
    return STRIDE * nch;
  endfunction
endpackage

// File: rtl/prog_timer_if.sv
// prog_timer_if: CPU register bus plus timer pulse/irq outputs
interface prog_timer_if #(parameter int NCH = 4) ();
  localparam int AW = $clog2(2 * NCH + 1);
  logic we;
  logic [AW-1:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [NCH-1:0] pulse;
  logic irq;
  modport master (output we, addr, wdata, input rdata, pulse, irq);
  modport slave (input we, addr, wdata, output rdata, pulse, irq);
endinterface

// File: rtl/prog_timer_channel.sv
// timer_channel: one programmable interval counter with period/ctrl storage and one-shot auto-clear
module timer_channel
  import prog_timer_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              period_we,
  input  logic              ctrl_we,
  input  logic [CW-1:0]     period_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic [CW-1:0]     period,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pulse,
  output logic              tc
);
  logic [CW-1:0] count;
  logic active;
  assign active = ctrl[CTRL_EN] && period != '0;
  assign tc = active && !period_we && !ctrl_we && count == period - CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      ctrl <= '0;
      count <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= tc;
      if (period_we) begin
        period <= period_d;
        count <= '0;
      end else if (ctrl_we) begin
        ctrl <= ctrl_d;
        count <= '0;
      end else if (!active || tc) begin
        count <= '0;
        if (tc && ctrl[CTRL_ONESHOT]) ctrl[CTRL_EN] <= 1'b0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end
endmodule

// File: rtl/prog_timer.sv
// prog_timer: NCH-channel programmable interval timer with W1C status and combined irq
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW = 16
) (
  input logic clk,
  input logic reset,
  prog_timer_if.slave bus
);
  localparam int AW = $clog2(2 * NCH + 1);
  logic [CW-1:0] period [NCH];
  logic [CTRL_W-1:0] ctrl [NCH];
  logic [NCH-1:0] tc, ie, pending, clr, pulse;
  logic irq;
  logic [15:0] rdata;
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(.CW(CW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .period_we (bus.we && bus.addr == AW'(STRIDE * i + PERIOD_OFS)),
      .ctrl_we   (bus.we && bus.addr == AW'(STRIDE * i + CTRL_OFS)),
      .period_d  (bus.wdata[CW-1:0]),
      .ctrl_d    (bus.wdata[CTRL_W-1:0]),
      .period    (period[i]),
      .ctrl      (ctrl[i]),
      .pulse     (pulse[i]),
      .tc        (tc[i])
    );
    assign ie[i] = ctrl[i][CTRL_IE];
  end
  assign clr = (bus.we && bus.addr == AW'(status_addr(NCH))) ? bus.wdata[NCH-1:0] : '0;
  // a terminal count on the same edge as a W1C keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      irq <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | tc;
      irq <= |(pending & ie);
    end
  end
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.addr == AW'(STRIDE * k + PERIOD_OFS)) rdata = 16'(period[k]);
      if (bus.addr == AW'(STRIDE * k + CTRL_OFS)) rdata = 16'(ctrl[k]);
    end
    if (bus.addr == AW'(status_addr(NCH))) rdata = 16'(pending);
  end
  assign bus.rdata = rdata;
  assign bus.pulse = pulse;
  assign bus.irq = irq;
endmodule

// File: doc/prog_timer.md
# prog_timer

Multi-channel programmable interval timer on the CPU's 16-bit I/O bus. Successor to the fixed-period single-output timer: NCH independent channels with CPU-writable periods, enable/one-shot/interrupt-enable control, one-cycle pulse outputs, sticky pending flags with write-1-to-clear, and a combined interrupt line. It sits beside the I/O transceiver and is addressed by the CPU's register-mapped I/O decode.

## Interface
- NCH, 4, number of timer channels (1..8)
- CW, 16, counter/period width in bits (1..16)
- AW, $clog2(2*NCH+1), register address width (derived, not overridden)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- we  input  1  register write strobe, one write per cycle
- addr  input  AW  register address for read and write
- wdata  input  16  write data
- rdata  output  16  read data, combinational from addr
- pulse  output  NCH  per-channel one-cycle terminal-count pulse, registered
- irq  output  1  OR of (pending[i] & ie[i]), registered

## Operation
- Register map: addr 2*i = PERIOD[i] (bits CW-1:0); addr 2*i+1 = CTRL[i] (bit0 en, bit1 oneshot, bit2 ie); addr 2*NCH = STATUS (bits NCH-1:0 pending, write-1-to-clear). Other addresses: reads 0, writes ignored.
- Reads: PERIOD and CTRL return stored values zero-extended; STATUS returns pending zero-extended. Read has no side effects.
- Reset: all PERIOD, CTRL, count, pending, pulse, irq = 0; rdata follows addr (STATUS reads 0).
- Per channel, each edge, priority high to low:
  - write to PERIOD[i]: store value, count <= 0, no pulse.
  - write to CTRL[i]: store bits; count <= 0, no pulse.
  - en=0 or PERIOD=0: count holds 0, no pulse.
  - count == PERIOD-1: count <= 0, pulse[i] <= 1, pending[i] <= 1; if oneshot, en <= 0.
  - else count <= count+1.
- pulse[i] is 0 on every edge not meeting the terminal condition.
- PERIOD=1: pulse every cycle while en=1 (periodic mode).
- STATUS write: pending[i] <= 0 where wdata[i]=1; if same edge sets pending[i], set wins.
- Count arithmetic is CW bits, never wraps past PERIOD-1; PERIOD = 2^CW-1 max.

## Timing
- Edge 0 writes CTRL with en=1 (PERIOD=P already set): count=0 after edge 0; first pulse high in cycle after edge P; subsequent pulses every P cycles.
- One-shot: single pulse after edge P, en reads 0 from that cycle on.
- irq registered: asserts one cycle after pending&ie becomes true, deasserts one cycle after W1C or ie cleared.
- rdata: zero-cycle combinational; reflects register state after the last edge.
- Reset mid-count: on the reset edge all state clears; no pulse on that edge.

## Structure
- Package prog_timer_pkg: register offsets (PERIOD, CTRL stride 2, STATUS base), CTRL bit positions (EN=0, ONESHOT=1, IE=2).
- Sub-module timer_channel (CW parameter): period/ctrl storage, counter, pulse, pending-set output, one-shot auto-clear. Top instantiates NCH copies via generate, holds pending/STATUS, irq, and read mux.

## Test plan
- Reset then read all addresses -> all 0; pulse=0, irq=0.
- PERIOD[0]=4, CTRL[0]=0b001 -> pulse[0] high after edges 4, 8, 12; STATUS reads 0x0001; irq stays 0.
- PERIOD[1]=3, CTRL[1]=0b111 (one-shot, ie) -> single pulse[1] after edge 3, CTRL[1] reads 0b110, irq=1 next cycle; write STATUS=0x0002 -> irq=0 one cycle later.
- Channel 2 PERIOD=1 periodic -> pulse[2] every cycle; PERIOD=0 -> no pulses, count held.
- W1C STATUS on same edge as channel 0 terminal count -> pending[0] remains 1.
- Rewrite PERIOD[0]=10 mid-count at count 2 -> no pulse that edge, next pulse 10 edges later; reset asserted mid-count -> all outputs 0 next cycle.
